// File: rtl/digit_overlay_render_pkg.sv
// Shared constants and types for the digit overlay renderer.
// Glyph geometry, overlay colours and the stage-1 pipeline record live here.
package digit_overlay_render_pkg;

  localparam int GLYPH_W     = 8;
  localparam int GLYPH_H     = 16;
  localparam int GLYPH_SCALE = 2;
  localparam int CELL_W      = GLYPH_W * GLYPH_SCALE;
  localparam int CELL_H      = GLYPH_H * GLYPH_SCALE;

  localparam int MAX_DIGITS_DEF = 8;

  localparam logic [23:0] COLOR_TEXT = 24'hFFFFFF;
  localparam logic [23:0] COLOR_BOX  = 24'hFF0000;
  localparam logic [23:0] COLOR_SCAN = 24'h00FF00;

  // Everything stage 2 needs besides the glyph row, aligned with the ROM read.
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] data;
    logic        in_text;
    logic [2:0]  gcol;
    logic        box_hit;
    logic        scan_hit;
  } stage1_t;

endpackage

// File: rtl/digit_overlay_render_if.sv
// Video in/out, digit push handshake and recognition-box geometry bundle.
interface digit_overlay_render_if;
  logic        i_hs, i_vs, i_de;
  logic [11:0] i_x, i_y;
  logic [23:0] i_data;
  logic        digit_valid;
  logic [3:0]  digit_code;
  logic        digit_ready;
  logic [11:0] char_up, char_down, char_left, char_right;
  logic [11:0] row_scanf_line1, row_scanf_line2;
  logic        o_hs, o_vs, o_de;
  logic [11:0] o_x, o_y;
  logic [23:0] o_data;
  logic        overflow;

  modport master (
    output i_hs, i_vs, i_de, i_x, i_y, i_data, digit_valid, digit_code,
           char_up, char_down, char_left, char_right, row_scanf_line1, row_scanf_line2,
    input  digit_ready, o_hs, o_vs, o_de, o_x, o_y, o_data, overflow
  );

  modport slave (
    input  i_hs, i_vs, i_de, i_x, i_y, i_data, digit_valid, digit_code,
           char_up, char_down, char_left, char_right, row_scanf_line1, row_scanf_line2,
    output digit_ready, o_hs, o_vs, o_de, o_x, o_y, o_data, overflow
  );
endinterface

// File: rtl/digit_overlay_render_rom.sv
// 8x16 digit glyph ROM with a registered read; codes 10-15 are blank.
module digit_glyph_rom
  import digit_overlay_render_pkg::*;
(
  input  logic               clk,
  input  logic [3:0]         code,
  input  logic [3:0]         row,
  output logic [GLYPH_W-1:0] glyph
);

  // Sixteen rows per glyph, row 0 in the top byte, bit 7 is the leftmost column.
  function automatic logic [127:0] glyph_rows(input logic [3:0] c);
    case (c)
      4'd0:    glyph_rows = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
      4'd1:    glyph_rows = 128'h00001838781818181818187E00000000;
      4'd2:    glyph_rows = 128'h00007CC6060C183060C0C6FE00000000;
      4'd3:    glyph_rows = 128'h00007CC606063C060606C67C00000000;
      4'd4:    glyph_rows = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
      4'd5:    glyph_rows = 128'h0000FEC0C0C0FC060606C67C00000000;
      4'd6:    glyph_rows = 128'h00003860C0C0FCC6C6C6C67C00000000;
      4'd7:    glyph_rows = 128'h0000FEC606060C183030303000000000;
      4'd8:    glyph_rows = 128'h00007CC6C6C67CC6C6C6C67C00000000;
      4'd9:    glyph_rows = 128'h00007CC6C6C67E0606060C7800000000;
      default: glyph_rows = '0;
    endcase
  endfunction

  logic [127:0] rows;
  assign rows = glyph_rows(code);

  always_ff @(posedge clk) begin
    glyph <= rows[{4'd15 - row, 3'b000} +: GLYPH_W];
  end

endmodule

// File: rtl/digit_overlay_render.sv
// Overlays a committed digit string, the recognition box and scan lines on video.
// Two-stage pipeline: stage 1 = geometry decode + glyph ROM read, stage 2 = colour select.
module digit_overlay_render
  import digit_overlay_render_pkg::*;
#(
  parameter int TEXT_X     = 16,
  parameter int TEXT_Y     = 16,
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  digit_overlay_render_if.slave  bus
);

  localparam int          IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int          CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [11:0] TX    = 12'(TEXT_X);
  localparam logic [11:0] TY    = 12'(TEXT_Y);

  logic [CNT_W-1:0] wr_cnt, disp_cnt;
  logic [3:0]       pending [MAX_DIGITS];
  logic [3:0]       disp    [MAX_DIGITS];
  logic             vs_q;
  logic [11:0]      up_r, down_r, left_r, right_r, line1_r, line2_r;
  logic             commit, wr_fire;

  assign bus.digit_ready = (wr_cnt < CNT_W'(MAX_DIGITS));
  assign wr_fire         = bus.digit_valid && bus.digit_ready;
  assign commit          = vs_q && !bus.i_vs;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q         <= 1'b0;
      wr_cnt       <= '0;
      disp_cnt     <= '0;
      bus.overflow <= 1'b0;
      {up_r, down_r, left_r, right_r, line1_r, line2_r} <= '0;
      // NOTE: the small digit buffers are cleared so no stale code survives a reset.
      for (int i = 0; i < MAX_DIGITS; i++) begin
        pending[i] <= '0;
        disp[i]    <= '0;
      end
    end else begin
      vs_q <= bus.i_vs;
      if (bus.digit_valid && !bus.digit_ready) bus.overflow <= 1'b1;
      if (commit) begin
        for (int i = 0; i < MAX_DIGITS; i++) disp[i] <= pending[i];
        disp_cnt <= wr_cnt;
        up_r     <= bus.char_up;
        down_r   <= bus.char_down;
        left_r   <= bus.char_left;
        right_r  <= bus.char_right;
        line1_r  <= bus.row_scanf_line1;
        line2_r  <= bus.row_scanf_line2;
        // A write racing the commit opens the next frame's buffer.
        wr_cnt   <= wr_fire ? CNT_W'(1) : '0;
        if (wr_fire) pending[0] <= bus.digit_code;
      end else if (wr_fire) begin
        pending[wr_cnt[IDX_W-1:0]] <= bus.digit_code;
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  logic [11:0]        dx, dy, text_w, mid;
  logic [3:0]         cell_code;
  logic [GLYPH_W-1:0] rom_q;
  stage1_t            s0, s1;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    s0        = '0;
    cell_code = 4'd0;
    dx        = bus.i_x - TX;
    dy        = bus.i_y - TY;
    text_w    = 12'(disp_cnt) * 12'(CELL_W);
    mid       = left_r + ((right_r - left_r) >> 1);
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (dx[11:4] == 8'(i)) cell_code = disp[i];
    end
    s0.hs       = bus.i_hs;
    s0.vs       = bus.i_vs;
    s0.de       = bus.i_de;
    s0.x        = bus.i_x;
    s0.y        = bus.i_y;
    s0.data     = bus.i_data;
    s0.in_text  = (bus.i_x >= TX) && (dx < text_w) && (bus.i_y >= TY) && (dy < 12'(CELL_H));
    s0.gcol     = dx[3:1];
    s0.box_hit  = ((bus.i_x == left_r || bus.i_x == right_r) && bus.i_y >= up_r && bus.i_y <= down_r) ||
                  ((bus.i_y == up_r || bus.i_y == down_r) && bus.i_x >= left_r && bus.i_x <= right_r);
    s0.scan_hit = ((bus.i_y == line1_r || bus.i_y == line2_r) && bus.i_x > left_r && bus.i_x <= right_r) ||
                  (bus.i_x == mid && bus.i_y > up_r && bus.i_y <= down_r);
  end

  digit_glyph_rom u_rom (
    .clk   (clk),
    .code  (cell_code),
    .row   (dy[4:1]),
    .glyph (rom_q)
  );

  always_ff @(posedge clk) begin
    if (rst) s1 <= '0;
    else     s1 <= s0;
  end

  logic [23:0] pix;

  always_comb begin
    pix = s1.data;
    if (s1.de) begin
      if (s1.in_text && rom_q[3'd7 - s1.gcol]) pix = COLOR_TEXT;
      else if (s1.box_hit)                     pix = COLOR_BOX;
      else if (s1.scan_hit)                    pix = COLOR_SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_hs   <= 1'b0;
      bus.o_vs   <= 1'b0;
      bus.o_de   <= 1'b0;
      bus.o_x    <= '0;
      bus.o_y    <= '0;
      bus.o_data <= '0;
    end else begin
      bus.o_hs   <= s1.hs;
      bus.o_vs   <= s1.vs;
      bus.o_de   <= s1.de;
      bus.o_x    <= s1.x;
      bus.o_y    <= s1.y;
      bus.o_data <= pix;
    end
  end

endmodule

// File: tb/tb_digit_overlay_render.sv
// Directed bench for digit_overlay_render: text, buffer overflow, commit race,
// box/scan priority, pipeline latency and mid-frame reset.
module tb_digit_overlay_render;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  localparam logic [23:0] BG = 24'hABCDEF;

  digit_overlay_render_if bus ();

  digit_overlay_render #(.TEXT_X(16), .TEXT_Y(16), .MAX_DIGITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] code);
    bus.digit_valid = 1'b1;
    bus.digit_code  = code;
    tick();
    bus.digit_valid = 1'b0;
  endtask

  task automatic commit_frame();
    bus.i_vs = 1'b1;
    tick();
    bus.i_vs = 1'b0;
    tick();
  endtask

  // Present one active pixel and wait out the two-cycle latency.
  task automatic pix(input logic [11:0] x, input logic [11:0] y, input logic [23:0] d, input logic de);
    bus.i_hs   = 1'b0;
    bus.i_vs   = 1'b0;
    bus.i_de   = de;
    bus.i_x    = x;
    bus.i_y    = y;
    bus.i_data = d;
    tick();
    tick();
  endtask

  initial begin
    bus.i_hs = 0; bus.i_vs = 0; bus.i_de = 0; bus.i_x = 0; bus.i_y = 0; bus.i_data = 0;
    bus.digit_valid = 0; bus.digit_code = 0;
    bus.char_up = 12'd200; bus.char_down = 12'd280;
    bus.char_left = 12'd100; bus.char_right = 12'd154;
    bus.row_scanf_line1 = 12'd220; bus.row_scanf_line2 = 12'd260;

    // Reset state
    tick(); tick();
    check("rst_o_data", bus.o_data, 24'h0);
    check("rst_o_x", bus.o_x, 12'h0);
    check("rst_o_de", bus.o_de, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    rst = 1'b0;
    check("rst_ready", bus.digit_ready, 1'b1);

    // No text before anything is committed
    pix(12'd32, 12'd20, BG, 1'b1);
    check("empty_text", bus.o_data, BG);

    // Digits 3,5,7
    push(4'd3); push(4'd5); push(4'd7);
    commit_frame();
    pix(12'd16, 12'd20, BG, 1'b1); check("d3_r2_c0", bus.o_data, BG);
    pix(12'd18, 12'd20, BG, 1'b1); check("d3_r2_c1", bus.o_data, 24'hFFFFFF);
    pix(12'd18, 12'd21, BG, 1'b1); check("d3_r2_c1_odd", bus.o_data, 24'hFFFFFF);
    pix(12'd18, 12'd16, BG, 1'b1); check("d3_r0_blank", bus.o_data, BG);
    pix(12'd20, 12'd28, BG, 1'b1); check("d3_r6_c2", bus.o_data, 24'hFFFFFF);
    pix(12'd32, 12'd20, BG, 1'b1); check("d5_r2_c0", bus.o_data, 24'hFFFFFF);
    pix(12'd46, 12'd20, BG, 1'b1); check("d5_r2_c7", bus.o_data, BG);
    pix(12'd56, 12'd28, BG, 1'b1); check("d7_r6_c4", bus.o_data, 24'hFFFFFF);
    pix(12'd57, 12'd28, BG, 1'b1); check("d7_r6_c4_odd", bus.o_data, 24'hFFFFFF);
    pix(12'd54, 12'd28, BG, 1'b1); check("d7_r6_c3", bus.o_data, BG);
    pix(12'd64, 12'd20, BG, 1'b1); check("past_text_x", bus.o_data, BG);
    pix(12'd18, 12'd48, BG, 1'b1); check("past_text_y", bus.o_data, BG);

    // Nine writes with digit_valid held
    bus.digit_valid = 1'b1;
    bus.digit_code  = 4'd1;
    for (int i = 0; i < 7; i++) tick();
    check("ready_after_7", bus.digit_ready, 1'b1);
    tick();
    check("ready_after_8", bus.digit_ready, 1'b0);
    check("ovf_after_8", bus.overflow, 1'b0);
    tick();
    check("ovf_after_9", bus.overflow, 1'b1);
    bus.digit_valid = 1'b0;
    commit_frame();
    check("ready_after_commit", bus.digit_ready, 1'b1);
    check("ovf_sticky", bus.overflow, 1'b1);
    pix(12'd134, 12'd20, BG, 1'b1); check("cell7_shown", bus.o_data, 24'hFFFFFF);
    pix(12'd144, 12'd20, BG, 1'b1); check("cell8_absent", bus.o_data, BG);

    // Write landing in the commit cycle
    push(4'd2);
    bus.i_vs = 1'b1;
    tick();
    bus.i_vs = 1'b0;
    bus.digit_valid = 1'b1;
    bus.digit_code  = 4'd9;
    tick();
    bus.digit_valid = 1'b0;
    pix(12'd16, 12'd38, BG, 1'b1); check("race_old_digit", bus.o_data, 24'hFFFFFF);
    pix(12'd32, 12'd20, BG, 1'b1); check("race_cnt1", bus.o_data, BG);
    commit_frame();
    pix(12'd16, 12'd38, BG, 1'b1); check("race_new_c0", bus.o_data, BG);
    pix(12'd18, 12'd38, BG, 1'b1); check("race_new_c1", bus.o_data, 24'hFFFFFF);

    // Box and scan lines
    pix(12'd100, 12'd240, 24'h123456, 1'b1); check("box_left", bus.o_data, 24'hFF0000);
    pix(12'd127, 12'd250, 24'h123456, 1'b1); check("scan_mid", bus.o_data, 24'h00FF00);
    pix(12'd130, 12'd220, 24'h123456, 1'b1); check("scan_line1", bus.o_data, 24'h00FF00);
    pix(12'd100, 12'd220, 24'h123456, 1'b1); check("box_over_scan", bus.o_data, 24'hFF0000);
    pix(12'd160, 12'd240, 24'h123456, 1'b1); check("outside_box", bus.o_data, 24'h123456);
    pix(12'd154, 12'd200, 24'h123456, 1'b1); check("box_corner", bus.o_data, 24'hFF0000);
    pix(12'd127, 12'd200, 24'h123456, 1'b1); check("box_top_mid", bus.o_data, 24'hFF0000);
    pix(12'd140, 12'd260, 24'h123456, 1'b1); check("scan_line2", bus.o_data, 24'h00FF00);
    pix(12'd127, 12'd281, 24'h123456, 1'b1); check("mid_below", bus.o_data, 24'h123456);

    // Pipeline latency of syncs, position and data
    for (int k = 0; k < 6; k++) begin
      bus.i_hs   = k[0];
      bus.i_vs   = k[1];
      bus.i_de   = 1'b1;
      bus.i_x    = 12'(500 + k);
      bus.i_y    = 12'(600 + 3 * k);
      bus.i_data = 24'(k * 24'h111111);
      tick();
      if (k >= 1) begin
        check("lat_hs", bus.o_hs, 32'((k - 1) & 1));
        check("lat_vs", bus.o_vs, 32'(((k - 1) >> 1) & 1));
        check("lat_x", bus.o_x, 32'(500 + k - 1));
        check("lat_y", bus.o_y, 32'(600 + 3 * (k - 1)));
        check("lat_data", bus.o_data, 32'((k - 1) * 24'h111111));
      end
    end
    pix(12'd100, 12'd240, 24'h123456, 1'b0);
    check("de0_data", bus.o_data, 24'h123456);
    check("de0_de", bus.o_de, 1'b0);

    // Reset mid-frame with four digits pending
    push(4'd4); push(4'd4); push(4'd4); push(4'd4);
    bus.i_hs = 1'b1; bus.i_de = 1'b1; bus.i_x = 12'd300; bus.i_y = 12'd300; bus.i_data = 24'hFFEEDD;
    tick(); tick();
    check("pre_rst_data", bus.o_data, 24'hFFEEDD);
    rst = 1'b1;
    tick();
    check("mid_rst_hs", bus.o_hs, 1'b0);
    check("mid_rst_de", bus.o_de, 1'b0);
    check("mid_rst_x", bus.o_x, 12'h0);
    check("mid_rst_y", bus.o_y, 12'h0);
    check("mid_rst_data", bus.o_data, 24'h0);
    check("mid_rst_ovf", bus.overflow, 1'b0);
    check("mid_rst_ready", bus.digit_ready, 1'b1);
    rst = 1'b0;
    pix(12'd300, 12'd300, 24'h0A0B0C, 1'b1); check("post_rst_pass", bus.o_data, 24'h0A0B0C);
    commit_frame();
    pix(12'd18, 12'd20, BG, 1'b1); check("post_rst_no_text", bus.o_data, BG);
    pix(12'd100, 12'd240, BG, 1'b1); check("post_rst_box", bus.o_data, 24'hFF0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
